// File: rtl/asip_mem_pkg.sv
// rtl/asip_mem_pkg.sv - shared defaults and types for the ASIP data memory responder
package asip_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2,
    RDRAIN = 2'd3
  } resp_state_t;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with one write port, async core read and registered host read
module dmem_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 24,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  caddr,
  output logic [DATA_W-1:0] crdata,
  input  logic              hrd_en,
  input  logic              hrd_zero,
  input  logic [IDX_W-1:0]  hraddr,
  output logic [DATA_W-1:0] hrdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign crdata = mem[caddr];

  // hrd_zero lets the owner substitute zero for an address it judged out of range
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hrdata <= '0;
    end else if (hrd_en) begin
      hrdata <= hrd_zero ? '0 : mem[hraddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - core data-port memory with host burst load/dump and core stall
module data_mem_responder #(
  parameter int ADDR_W = asip_mem_pkg::ADDR_W,
  parameter int DATA_W = asip_mem_pkg::DATA_W,
  parameter int DEPTH  = asip_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_we,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic              host_cmd_write,
  input  logic [ADDR_W-1:0] host_cmd_addr,
  input  logic [ADDR_W-1:0] host_cmd_len,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wdata_valid,
  output logic              host_wdata_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rdata_valid,
  input  logic              host_rdata_ready,
  output logic              oob_err
);
  import asip_mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  resp_state_t       state;
  logic [ADDR_W-1:0] baddr;
  logic [ADDR_W-1:0] brem;

  logic              idle;
  logic              core_in;
  logic              burst_in;
  logic              cmd_fire;
  logic              wfire;
  logic              rissue;
  logic              oob_now;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_crdata;

  assign idle     = (state == IDLE);
  assign core_in  = (int'(core_addr) < DEPTH);
  assign burst_in = (int'(baddr) < DEPTH);
  assign cmd_fire = idle && host_cmd_valid && host_cmd_ready;
  assign wfire    = (state == WBURST) && host_wdata_valid && host_wdata_ready;
  // a new read word may only replace one that is absent or leaving this cycle
  assign rissue   = (state == RBURST) && (!host_rdata_valid || host_rdata_ready);

  assign core_rdata = (idle && core_in) ? arr_crdata : '0;

  assign oob_now = (idle && core_we && !core_in) || ((wfire || rissue) && !burst_in);

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = core_addr[IDX_W-1:0];
    arr_wdata = core_wdata;
    if (wfire) begin
      arr_we    = burst_in;
      arr_waddr = baddr[IDX_W-1:0];
      arr_wdata = host_wdata;
    end else if (idle && core_we) begin
      arr_we = core_in;
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (arr_we),
    .waddr    (arr_waddr),
    .wdata    (arr_wdata),
    .caddr    (core_addr[IDX_W-1:0]),
    .crdata   (arr_crdata),
    .hrd_en   (rissue),
    .hrd_zero (!burst_in),
    .hraddr   (baddr[IDX_W-1:0]),
    .hrdata   (host_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      baddr            <= '0;
      brem             <= '0;
      core_stall       <= 1'b0;
      host_cmd_ready   <= 1'b0;
      host_wdata_ready <= 1'b0;
      host_rdata_valid <= 1'b0;
      oob_err          <= 1'b0;
    end else begin
      oob_err <= oob_now;
      case (state)
        IDLE: begin
          host_cmd_ready <= 1'b1;
          if (cmd_fire && (host_cmd_len != '0)) begin
            baddr          <= host_cmd_addr;
            brem           <= host_cmd_len;
            host_cmd_ready <= 1'b0;
            core_stall     <= 1'b1;
            if (host_cmd_write) begin
              state            <= WBURST;
              host_wdata_ready <= 1'b1;
            end else begin
              state <= RBURST;
            end
          end
        end
        WBURST: begin
          if (wfire) begin
            baddr <= baddr + 1'b1;
            brem  <= brem - 1'b1;
            if (brem == ADDR_W'(1)) begin
              state            <= IDLE;
              host_wdata_ready <= 1'b0;
              core_stall       <= 1'b0;
              host_cmd_ready   <= 1'b1;
            end
          end
        end
        RBURST: begin
          if (rissue) begin
            host_rdata_valid <= 1'b1;
            baddr            <= baddr + 1'b1;
            brem             <= brem - 1'b1;
            if (brem == ADDR_W'(1)) begin
              state <= RDRAIN;
            end
          end
        end
        RDRAIN: begin
          if (host_rdata_valid && host_rdata_ready) begin
            host_rdata_valid <= 1'b0;
            state            <= IDLE;
            core_stall       <= 1'b0;
            host_cmd_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with behavioural memory model for data_mem_responder
module tb_data_mem_responder;
  import asip_mem_pkg::*;

  localparam int DP = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] core_addr;
  logic [23:0] core_wdata;
  logic        core_we;
  logic [23:0] core_rdata;
  logic        core_stall;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic        host_cmd_write;
  logic [15:0] host_cmd_addr;
  logic [15:0] host_cmd_len;
  logic [23:0] host_wdata;
  logic        host_wdata_valid;
  logic        host_wdata_ready;
  logic [23:0] host_rdata;
  logic        host_rdata_valid;
  logic        host_rdata_ready;
  logic        oob_err;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_write(host_cmd_write), .host_cmd_addr(host_cmd_addr), .host_cmd_len(host_cmd_len),
    .host_wdata(host_wdata), .host_wdata_valid(host_wdata_valid), .host_wdata_ready(host_wdata_ready),
    .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid), .host_rdata_ready(host_rdata_ready),
    .oob_err(oob_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: word memory, burst bookkeeping, queue of words a read burst must deliver
  typedef struct {word_t d; bit oob; bit kn;} rword_t;
  word_t       mem_m [DP];
  bit          known [DP];
  rword_t      rq[$];
  bit          busy, bw, fresh, oob_pend, prev_valid, last_hs, cmp_en;
  logic [15:0] b_addr, b_rem;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy = 0; fresh = 1; oob_pend = 0; prev_valid = 0; last_hs = 0;
      rq.delete();
    end else begin
      oob_pend   = 0;
      last_hs    = host_rdata_valid && host_rdata_ready;
      prev_valid = host_rdata_valid;
      if (!busy) begin
        if (core_we) begin
          if (core_addr < DP) begin
            mem_m[core_addr] = core_wdata;
            known[core_addr] = 1;
          end else oob_pend = 1;
        end
        if (!fresh && host_cmd_valid && host_cmd_len != 0) begin
          busy = 1; bw = host_cmd_write; b_addr = host_cmd_addr; b_rem = host_cmd_len;
          if (!bw) begin
            for (int i = 0; i < int'(host_cmd_len); i++) begin
              logic [15:0] a;
              rword_t w;
              a = host_cmd_addr + 16'(i);
              w.oob = (a >= DP);
              w.d   = w.oob ? 24'h0 : mem_m[a[11:0]];
              w.kn  = w.oob ? 1'b1 : known[a[11:0]];
              rq.push_back(w);
            end
          end
        end
      end else if (bw) begin
        if (host_wdata_valid) begin
          if (b_addr < DP) begin
            mem_m[b_addr[11:0]] = host_wdata;
            known[b_addr[11:0]] = 1;
          end else oob_pend = 1;
          b_addr = b_addr + 16'd1;
          b_rem  = b_rem - 16'd1;
          if (b_rem == 0) busy = 0;
        end
      end else if (last_hs && rq.size() > 0) begin
        void'(rq.pop_front());
        if (rq.size() == 0) busy = 0;
      end
      fresh = 0;
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      bit nw;
      chk("stall", core_stall, busy);
      chk("cmd_ready", host_cmd_ready, !busy && !fresh);
      chk("wdata_ready", host_wdata_ready, busy && bw);
      if (busy) chk("core_rdata_stalled", core_rdata, 0);
      else if (core_addr >= DP) chk("core_rdata_oob", core_rdata, 0);
      else if (known[core_addr[11:0]]) chk("core_rdata", core_rdata, mem_m[core_addr[11:0]]);
      if (!(busy && !bw)) begin
        chk("rvalid_quiet", host_rdata_valid, 0);
        chk("oob", oob_err, oob_pend);
      end else if (host_rdata_valid) begin
        nw = !prev_valid || last_hs;
        if (rq[0].kn) chk("rdata", host_rdata, rq[0].d);
        chk("oob_rd", oob_err, oob_pend || (nw && rq[0].oob));
      end else begin
        chk("oob", oob_err, oob_pend);
      end
    end
  end

  int stall_cnt, oob_cnt;
  always @(negedge clk) begin
    if (core_stall) stall_cnt++;
    if (oob_err) oob_cnt++;
  end

  bit          noise;
  logic [23:0] rd_log[$];
  bit   [3:0]  pat = 4'b1101;

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(9);
    if (r == 0) return 16'hFFFF - 16'($urandom_range(3));
    if (r == 1) return 16'h1000 + 16'($urandom_range(3));
    if (r == 2) return 16'h0FFE + 16'($urandom_range(1));
    return 16'($urandom_range(DP - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_core();
    if (noise) begin
      core_we    = ($urandom_range(3) == 0);
      core_addr  = pick_addr();
      core_wdata = 24'($urandom);
    end
  endtask

  task automatic send_cmd(input bit w, input logic [15:0] a, input logic [15:0] n);
    bit r;
    int t = 0;
    host_cmd_valid = 1; host_cmd_write = w; host_cmd_addr = a; host_cmd_len = n;
    do begin
      @(negedge clk);
      r = host_cmd_ready;
      step();
      t++;
    end while (!r && t < 50);
    if (!r) chk("cmd_accept_timeout", r, 1);
    host_cmd_valid = 0;
  endtask

  task automatic write_words(input int n, input bit seq, input logic [23:0] base, input int gap);
    for (int i = 0; i < n; i++) begin
      bit r;
      int t = 0;
      if (gap != 0 && $urandom_range(99) < gap) begin
        host_wdata_valid = 0;
        rand_core();
        step();
      end
      host_wdata_valid = 1;
      host_wdata = seq ? base + 24'(i) : 24'($urandom);
      do begin
        rand_core();
        @(negedge clk);
        r = host_wdata_ready;
        step();
        t++;
      end while (!r && t < 50);
      if (!r) chk("wdata_timeout", r, 1);
    end
    host_wdata_valid = 0;
  endtask

  task automatic read_words(input int n, input bit use_pat);
    int got = 0, t = 0, k = 0;
    while (got < n && t < 400) begin
      host_rdata_ready = use_pat ? pat[k % 4] : ($urandom_range(1) == 1);
      k++;
      rand_core();
      @(negedge clk);
      if (host_rdata_valid && host_rdata_ready) begin
        rd_log.push_back(host_rdata);
        got++;
      end
      step();
      t++;
    end
    if (got != n) chk("read_count", got, n);
    host_rdata_ready = 0;
  endtask

  initial begin
    rst = 0; cmp_en = 0; noise = 0;
    core_addr = 0; core_wdata = 0; core_we = 0;
    host_cmd_valid = 0; host_cmd_write = 0; host_cmd_addr = 0; host_cmd_len = 0;
    host_wdata = 0; host_wdata_valid = 0; host_rdata_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", core_stall, 0);
    chk("rst_cmd_ready", host_cmd_ready, 0);
    chk("rst_wdata_ready", host_wdata_ready, 0);
    chk("rst_rvalid", host_rdata_valid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_oob", oob_err, 0);
    step();
    rst = 1; cmp_en = 1;
    step();

    send_cmd(1, 16'h0000, 16'(DP));
    write_words(DP, 0, 24'h0, 0);
    step();

    core_we = 1; core_addr = 16'h0010; core_wdata = 24'hA1B2C3;
    step();
    core_we = 0;
    #1 chk("t1_readback", core_rdata, 24'hA1B2C3);

    stall_cnt = 0;
    send_cmd(1, 16'h0100, 16'd3);
    write_words(3, 1, 24'h000001, 100);
    step(); step();
    chk("t2_stall_cycles", stall_cnt >= 4, 1);
    core_addr = 16'h0101;
    #1 chk("t2_readback", core_rdata, 24'h000002);
    chk("t2_stall_low", core_stall, 0);

    rd_log.delete();
    send_cmd(0, 16'h0100, 16'd3);
    read_words(3, 1);
    step(); step();
    chk("t3_w0", rd_log[0], 24'h000001);
    chk("t3_w1", rd_log[1], 24'h000002);
    chk("t3_w2", rd_log[2], 24'h000003);
    chk("t3_idle", core_stall, 0);

    core_we = 1; core_addr = 16'h0020; core_wdata = 24'h123456;
    step();
    core_addr = 16'h0FFF; core_wdata = 24'h0F0F0F;
    send_cmd(1, 16'h0200, 16'd1);
    core_addr = 16'h0020; core_wdata = 24'hDEAD00;
    @(negedge clk);
    chk("t4_stall_rise", core_stall, 1);
    step();
    write_words(1, 1, 24'h111111, 0);
    core_we = 0;
    step();
    core_addr = 16'h0FFF;
    #1 chk("t4_fff", core_rdata, 24'h0F0F0F);
    core_addr = 16'h0020;
    #1 chk("t4_020", core_rdata, 24'h123456);

    core_we = 1; core_addr = 16'h1000; core_wdata = 24'h777777;
    step();
    core_we = 0;
    @(negedge clk);
    chk("t5_oob_pulse", oob_err, 1);
    chk("t5_oob_read", core_rdata, 0);
    step();
    @(negedge clk);
    chk("t5_oob_clear", oob_err, 0);
    core_we = 1; core_addr = 16'h0000; core_wdata = 24'h5A5A5A;
    step();
    core_we = 0;
    rd_log.delete();
    oob_cnt = 0;
    send_cmd(0, 16'hFFFF, 16'd2);
    read_words(2, 0);
    step(); step();
    chk("t5_w0", rd_log[0], 24'h000000);
    chk("t5_w1", rd_log[1], 24'h5A5A5A);
    chk("t5_oob_count", oob_cnt, 1);

    send_cmd(1, 16'h0300, 16'd4);
    write_words(1, 1, 24'hBEEF01, 0);
    #1 rst = 0;
    #1;
    chk("t6_stall", core_stall, 0);
    chk("t6_rvalid", host_rdata_valid, 0);
    chk("t6_wready", host_wdata_ready, 0);
    @(posedge clk);
    #2 rst = 1;
    step();
    core_addr = 16'h0300;
    #1 chk("t6_retained", core_rdata, 24'hBEEF01);

    noise = 1;
    repeat (250) begin
      int op;
      op = $urandom_range(9);
      if (op < 4) begin
        rand_core();
        step();
      end else begin
        logic [15:0] a, n;
        a = pick_addr();
        n = 16'($urandom_range(6));
        rand_core();
        send_cmd(op < 7, a, n);
        if (n != 0) begin
          if (op < 7) write_words(int'(n), 0, 24'h0, 30);
          else read_words(int'(n), 0);
        end
      end
    end
    noise = 0; core_we = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
